// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the program counter, presents the fetch
// address to the instruction RAM and captures the returned word into the
// IF/ID pipeline register. Supports sequential PC+4 fetch, branch redirect
// with a one-bubble flush, and hazard stalls that freeze the whole stage.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    // Word alignment mask: the PC never carries byte-offset bits.
    localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALGN = RESET_PC & WORD_MASK;

    // Architectural state of the stage.
    logic [31:0] pc_q,          pc_d;
    logic [31:0] ifid_instr_q,  ifid_instr_d;
    logic [31:0] ifid_pc4_q,    ifid_pc4_d;
    logic        ifid_valid_q,  ifid_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    // Decoded per-edge action. Redirect has priority over stall.
    logic        do_redirect;
    logic        do_advance;
    logic [31:0] pc_plus4;
    logic [31:0] target_algn;

    // Action decode and shared arithmetic.
    always_comb begin
        do_redirect = branch_taken;
        do_advance  = !branch_taken && !stall;
        pc_plus4    = pc_q + 32'd4;
        target_algn = branch_target & WORD_MASK;
    end

    // Next-state selection: redirect flushes IF/ID, stall holds, otherwise fetch.
    always_comb begin
        pc_d          = pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc4_d    = ifid_pc4_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;

        if (do_redirect) begin
            // Flushed slot becomes a bubble; the count tracks real instructions only.
            pc_d         = target_algn;
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = 32'd0;
            ifid_valid_d = 1'b0;
        end else if (do_advance) begin
            // The RAM word for the current PC is latched with its return address.
            pc_d          = pc_plus4;
            ifid_instr_d  = imem_data;
            ifid_pc4_d    = pc_plus4;
            ifid_valid_d  = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // State registers; reset clears the stage immediately, independent of clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC_ALGN;
            ifid_instr_q  <= NOP_INSTR;
            ifid_pc4_q    <= 32'd0;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Outputs come straight from registers; the RAM address is a copy of the PC.
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc4    = ifid_pc4_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized stall/branch/reset traffic against a behavioural model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    // Instruction RAM image: 256 bytes = 64 words, addressed by byte address.
    logic [31:0] mem [64];

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the stage.
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .pc            (pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .fetch_count   (fetch_count)
    );

    assign imem_data = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 32'h0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc,                 m_pc);
        chk({tag, ".addr"},  imem_addr,          m_pc);
        chk({tag, ".instr"}, ifid_instr,         m_instr);
        chk({tag, ".pc4"},   ifid_pc4,           m_pc4);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
        chk({tag, ".cnt"},   fetch_count,        m_cnt);
    endtask

    // One clock edge with the given controls; the model applies the rules
    // for that edge, and outputs are compared 1 time unit after it.
    task automatic step(input string tag, input logic st, input logic br, input logic [31:0] tgt);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        #1;
        // Controls changed, no edge yet: registered outputs must not move.
        chk({tag, ".pre_pc"}, pc, m_pc);
        @(posedge clk);
        if (br) begin
            m_pc    = {tgt[31:2], 2'b00};
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
        end else if (!st) begin
            m_instr = mem[m_pc[7:2]];
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end
        #1;
        check_all(tag);
        stall        = 1'b0;
        branch_taken = 1'b0;
    endtask

    // Raise reset between edges and confirm the clear happens without an edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all({tag, ".rel"});
    endtask

    initial begin
        logic [31:0] pc_before;
        logic [31:0] cnt_before;
        logic [31:0] t;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'hE3A0_1001;
        mem[1] = 32'hE281_1002;
        mem[2] = 32'hE081_2001;

        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        reset = 1'b1;
        model_reset();
        #3;
        check_all("rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset then run, with a 2-edge stall at pc=8.
        step("run0", 1'b0, 1'b0, 32'h0);
        chk("run0.word", ifid_instr, 32'hE3A0_1001);
        chk("run0.pc4",  ifid_pc4,   32'd4);
        step("run1", 1'b0, 1'b0, 32'h0);
        chk("run1.word", ifid_instr, 32'hE281_1002);
        chk("run1.pc",   pc,         32'd8);
        step("stall0", 1'b1, 1'b0, 32'h0);
        step("stall1", 1'b1, 1'b0, 32'h0);
        chk("stall.pc",  pc,          32'd8);
        chk("stall.cnt", fetch_count, 32'd2);
        step("run2", 1'b0, 1'b0, 32'h0);
        chk("run2.word", ifid_instr,  32'hE081_2001);
        chk("run2.pc4",  ifid_pc4,    32'd12);
        chk("run2.cnt",  fetch_count, 32'd3);
        chk("run2.pc",   pc,          32'd12);

        // Branch to an unaligned target: aligned PC, one bubble.
        step("br", 1'b0, 1'b1, 32'h0000_001E);
        chk("br.pc",    pc,                  32'h1C);
        chk("br.valid", {31'd0, ifid_valid}, 32'd0);
        step("br_next", 1'b0, 1'b0, 32'h0);
        chk("br_next.word", ifid_instr, mem[7]);
        chk("br_next.pc4",  ifid_pc4,   32'h20);

        // Branch and stall on the same edge: redirect wins.
        cnt_before = fetch_count;
        step("brst", 1'b1, 1'b1, 32'h0000_0040);
        chk("brst.pc",  pc,          32'h40);
        chk("brst.cnt", fetch_count, cnt_before);

        // Async reset at pc=0x10.
        async_reset("ar0");
        for (int i = 0; i < 4; i++) step("ar_run", 1'b0, 1'b0, 32'h0);
        chk("ar.pc", pc, 32'h10);
        async_reset("ar1");

        // PC wrap.
        step("wrap_br", 1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("wrap_br.pc", pc, 32'hFFFF_FFFC);
        step("wrap0", 1'b0, 1'b0, 32'h0);
        chk("wrap0.pc",  pc,       32'h0);
        chk("wrap0.pc4", ifid_pc4, 32'h0);
        step("wrap1", 1'b0, 1'b0, 32'h0);
        chk("wrap1.pc",  pc,       32'h4);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            t = $urandom;
            pc_before = m_pc;
            if ($urandom_range(0, 99) < 3) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd",
                     ($urandom_range(0, 99) < 25),
                     ($urandom_range(0, 99) < 15),
                     ($urandom_range(0, 1) == 0) ? t : {24'h0, t[7:0]});
            end
            if (pc_before == 32'hFFFF_FFFF) $display("unreachable");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=%08h expected=%08h", 32'd0, 32'd1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch (IF) stage of the pipelined RISC core. Holds the program counter, drives the byte address into `inst_ram256x8`, and captures the returned 32-bit instruction word into the IF/ID pipeline register. It sequences PC+4 fetches, redirects on taken branches with a one-bubble flush, and freezes on hazard stalls. It sits directly upstream of the instruction RAM and feeds the decode/control-unit stage.

## Interface
- `RESET_PC`, 32'h00000000, PC value loaded on reset.
- `NOP_INSTR`, 32'h00000000, word inserted into IF/ID on reset and flush.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; all state is cleared immediately on assertion.
- `stall` in 1: from the hazard unit; holds PC and IF/ID.
- `branch_taken` in 1: redirect request from the branch-resolution stage.
- `branch_target` in 32: redirect byte address.
- `imem_addr` out 32: byte address to the instruction RAM `Address`; combinational copy of `pc`.
- `imem_data` in 32: instruction word from RAM `DataOut`, valid combinationally within the cycle.
- `pc` out 32: current fetch PC.
- `ifid_instr` out 32: latched instruction.
- `ifid_pc4` out 32: PC+4 of the latched instruction.
- `ifid_valid` out 1: 1 = IF/ID holds a real instruction; 0 = bubble.
- `fetch_count` out 32: number of valid instructions latched since reset.

## Operation
- Reset values: `pc`=RESET_PC, `ifid_instr`=NOP_INSTR, `ifid_pc4`=0, `ifid_valid`=0, `fetch_count`=0. `imem_addr` follows `pc`, so it equals RESET_PC during reset.
- Each rising edge, evaluated in priority order (`reset` is outside this order because it is asynchronous):
  - Redirect (`branch_taken`=1): `pc`←{branch_target[31:2],2'b00}. `ifid_instr`←NOP_INSTR, `ifid_pc4`←0, `ifid_valid`←0. `fetch_count` is unchanged. Redirect beats `stall`.
  - Stall (`stall`=1, no branch): all registers hold their values.
  - Sequential (neither asserted): `ifid_instr`←imem_data, `ifid_pc4`←pc+4, `ifid_valid`←1, `pc`←pc+4, `fetch_count`←fetch_count+1.
- Effective states are derived from `ifid_valid`:
  - BUBBLE (valid=0): entered on reset or redirect. Exits to VALID on the next sequential edge.
  - VALID (valid=1): remains VALID on sequential and stall edges. Exits to BUBBLE on redirect.
- Arithmetic:
  - PC increments by 4, modulo 2^32 (0xFFFFFFFC+4 → 0x00000000).
  - `fetch_count` wraps modulo 2^32.
  - The PC is always word-aligned: the low two bits of RESET_PC and `branch_target` are forced to 0.
  - No range check against RAM size; address decoding is owned by the RAM.

## Timing
- Address-to-IF/ID latency: 1 cycle. The word at `pc` in cycle n appears on `ifid_instr` after edge n+1.
- Redirect penalty: 1 bubble cycle. The target instruction is valid in IF/ID 2 edges after `branch_taken` is sampled.
- `stall` and `branch_taken` are sampled only at the rising edge. Their levels between edges have no effect.
- Reset mid-operation: outputs take reset values asynchronously, without waiting for an edge. The first edge after deassertion latches `imem_data` at RESET_PC (sequential rule).
- No combinational path from `stall`/`branch_*` to any output; `imem_addr` depends only on the `pc` register.

## Test plan
- Reset then run: RAM words 0xE3A01001 @0, 0xE2811002 @4, 0xE0812001 @8; release `reset`; 3 edges. Required: `ifid_instr` sequence 0xE3A01001, 0xE2811002, 0xE0812001; `ifid_pc4` = 4, 8, 12; `fetch_count`=3; `pc`=12.
- Stall: assert `stall` for 2 edges while `pc`=8. Required: `pc`, IF/ID and `fetch_count` unchanged across both edges; resumes at `pc`=8 on release.
- Branch: `branch_taken`=1, `branch_target`=0x1E at `pc`=12. Required after the edge: `pc`=0x1C, `ifid_instr`=NOP_INSTR, `ifid_valid`=0. On the next edge, IF/ID holds word @0x1C with `ifid_pc4`=0x20.
- Branch with stall in the same edge: `stall`=1 and `branch_taken`=1. Required: redirect applied, IF/ID flushed, `fetch_count` unchanged.
- Async reset mid-run: raise `reset` between edges at `pc`=0x10. Required: `pc`=0, `ifid_valid`=0, `fetch_count`=0 before the next edge.
- Wrap: force PC to 0xFFFFFFFC via branch, then 2 sequential edges. Required: `pc`=0x00000000, then 0x00000004.
